// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array slice.
//   ARRAY_N      : array dimension (rows, and elements per activation vector)
//   ACT_W        : width of one activation element
//   act_t        : one activation element
//   feed_state_t : activation skew feeder FSM states
package systolic_pkg;

    localparam int ARRAY_N = 4;
    localparam int ACT_W   = 8;

    typedef logic [ACT_W-1:0] act_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feed_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-latency shift register of {valid, data}. One row of the feeder uses one
// instance. The output is the last register stage, so the latency is exactly
// DEPTH cycles and the output is always registered.
// Ports:
//   clk       : system clock
//   n_rst     : asynchronous active-low reset, clears every stage
//   in_valid  : valid bit entering the head stage
//   in_data   : data entering the head stage
//   out_valid : valid bit leaving the tail stage
//   out_data  : data leaving the tail stage
module skew_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0]             vld_q;
    logic [DEPTH-1:0][DATA_W-1:0] dat_q;

    // NOTE: the stages are a shift register, not a RAM, so clearing them on reset
    // is cheap and guarantees no stale element is ever flagged valid downstream.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's
            // old value, which is what makes this a shift rather than a wire.
            vld_q[0] <= in_valid;
            dat_q[0] <= in_data;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
                dat_q[k] <= dat_q[k-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Activation skew feeder: accepts one N-wide activation vector per cycle and
// presents it to the systolic array's west edge as a diagonal wavefront. Row i
// carries element i, delayed i+1 cycles. After the last vector of a tile the
// skew drains and done pulses in the cycle the final element leaves row N-1.
// Ports:
//   clk       : system clock
//   n_rst     : asynchronous active-low reset
//   in_valid  : in_data / in_last valid this cycle
//   in_ready  : a vector can be accepted this cycle
//   in_data   : activation vector, element i at [i*DATA_W +: DATA_W]
//   in_last   : the accepted vector ends the tile
//   out_data  : per-row activation, row i at [i*DATA_W +: DATA_W]
//   out_valid : row i carries a real element (not a bubble)
//   busy      : a tile is in flight
//   done      : one-cycle pulse, last element has left row N-1
module act_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N      = ARRAY_N,
    parameter int DATA_W = ACT_W
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic                in_last,
    output logic [N*DATA_W-1:0] out_data,
    output logic [N-1:0]        out_valid,
    output logic                busy,
    output logic                done
);

    // One extra bit so the counter is at least 1 bit wide when N = 1.
    localparam int                CNT_W    = $clog2(N) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N - 1);

    feed_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, busy_q, done_q;
    logic             accept;
    logic             drain_final_d;

    assign accept = in_valid && in_ready_q;

    // Next-state logic. A vector may be accepted in the final drain cycle, so the
    // accept branch is shared between IDLE, STREAM and the end of DRAIN.
    // NOTE: every variable gets a default at the top so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    state_d = in_last ? DRAIN : STREAM;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (accept) state_d = in_last ? DRAIN : STREAM;
                    else        state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The last drain cycle is the one where row N-1 shows the final element:
    // done fires, busy drops and the feeder reopens for the next tile.
    assign drain_final_d = (state_d == DRAIN) && (cnt_d == LAST_CNT);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= (state_d != DRAIN) || drain_final_d;
            busy_q     <= (state_d != IDLE) && !drain_final_d;
            done_q     <= drain_final_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Row i is delayed i+1 cycles. Without an accept a zero bubble enters every
    // row, so idle cycles keep their place on the diagonal.
    for (genvar i = 0; i < N; i++) begin : g_row
        logic [DATA_W-1:0] head_data;

        assign head_data = accept ? in_data[i*DATA_W +: DATA_W] : '0;

        skew_delay_line #(
            .DEPTH  (i + 1),
            .DATA_W (DATA_W)
        ) u_delay (
            .clk       (clk),
            .n_rst     (n_rst),
            .in_valid  (accept),
            .in_data   (head_data),
            .out_valid (out_valid[i]),
            .out_data  (out_data[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder (N=4, DATA_W=8). Inputs change 1 time unit
// after a rising edge and outputs are compared at that same point, i.e. cycle c
// below is the cycle that starts with the c-th edge after the accept edge.
module tb_act_skew_feeder;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk;
    logic            n_rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_data;
    logic            in_last;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_valid;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;

    act_skew_feeder #(.N(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_rst    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (2) step();
        @(negedge clk) n_rst = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_init: got %b want 1", in_ready);
        end
        // Put data in flight, then assert reset in the middle of a cycle.
        in_valid = 1'b1;
        in_data  = 32'hAABBCCDD;
        in_last  = 1'b0;
        step();
        in_valid = 1'b0;
        #3 n_rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h want 0/0", out_valid, out_data);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got done=%b busy=%b want 0/0", done, busy);
        end
        @(negedge clk) n_rst = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== '0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b valid=%b want 1/0000", in_ready, out_valid);
        end
    endtask

    // {4,3,2,1}: row r shows r+1 in cycle r+1 only.
    task automatic test_single();
        logic [N*DW-1:0] exp_d;
        logic [N-1:0]    exp_v;
        in_valid = 1'b1;
        in_data  = 32'h04030201;
        in_last  = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            exp_v = '0;
            exp_d = '0;
            if (c <= N) begin
                exp_v[c-1]        = 1'b1;
                exp_d[(c-1)*DW +: DW] = DW'(c);
            end
            checks++;
            if (out_valid !== exp_v || out_data !== exp_d) begin
                errors++;
                $display("FAIL single_out c=%0d: got %b/%h want %b/%h", c, out_valid, out_data, exp_v, exp_d);
            end
            checks++;
            if (done !== (c == N) || in_ready !== (c >= N) || busy !== (c < N)) begin
                errors++;
                $display("FAIL single_ctrl c=%0d: got done=%b ready=%b busy=%b want %b/%b/%b",
                         c, done, in_ready, busy, c == N, c >= N, c < N);
            end
            step();
        end
    endtask

    // Vectors k=1..4 back to back; row i shows k in cycle k+i.
    task automatic test_stream();
        logic [N*DW-1:0] exp_d;
        logic [N-1:0]    exp_v;
        logic [DW-1:0]   k;
        k        = 8'd1;
        in_valid = 1'b1;
        in_data  = {N{k}};
        in_last  = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c < 4) begin
                k       = DW'(c + 1);
                in_data = {N{k}};
                in_last = (c == 3);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            exp_v = '0;
            exp_d = '0;
            for (int i = 0; i < N; i++) begin
                if (c - i >= 1 && c - i <= 4) begin
                    exp_v[i]          = 1'b1;
                    exp_d[i*DW +: DW] = DW'(c - i);
                end
            end
            checks++;
            if (out_valid !== exp_v || out_data !== exp_d) begin
                errors++;
                $display("FAIL stream_out c=%0d: got %b/%h want %b/%h", c, out_valid, out_data, exp_v, exp_d);
            end
            checks++;
            if (done !== (c == 7) || in_ready !== !(c >= 4 && c <= 6) || busy !== (c < 7)) begin
                errors++;
                $display("FAIL stream_ctrl c=%0d: got done=%b ready=%b busy=%b", c, done, in_ready, busy);
            end
        end
    endtask

    // Vector 1, one idle cycle, then vectors 2..4 (last on 4, accepted at t+4).
    task automatic test_bubble();
        logic [DW-1:0]   seq [5];
        logic [N*DW-1:0] exp_d;
        logic [N-1:0]    exp_v;
        int              j;
        seq      = '{8'd1, 8'd0, 8'd2, 8'd3, 8'd4};
        in_valid = 1'b1;
        in_data  = {N{seq[0]}};
        in_last  = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c <= 4) begin
                in_valid = (seq[c] != 8'd0);
                in_data  = {N{seq[c]}};
                in_last  = (c == 4);
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
                in_last  = 1'b0;
            end
            exp_v = '0;
            exp_d = '0;
            for (int i = 0; i < N; i++) begin
                j = c - 1 - i;
                if (j >= 0 && j <= 4 && seq[j] != 8'd0) begin
                    exp_v[i]          = 1'b1;
                    exp_d[i*DW +: DW] = seq[j];
                end
            end
            checks++;
            if (out_valid !== exp_v || out_data !== exp_d) begin
                errors++;
                $display("FAIL bubble_out c=%0d: got %b/%h want %b/%h", c, out_valid, out_data, exp_v, exp_d);
            end
            checks++;
            if (done !== (c == 8)) begin
                errors++;
                $display("FAIL bubble_done c=%0d: got %b want %b", c, done, c == 8);
            end
        end
    endtask

    // Tile A (5s, last) at t; tile B (6s, last) held valid through A's drain and
    // accepted in t+4 when in_ready reopens.
    task automatic test_backpressure();
        logic [N*DW-1:0] exp_d;
        logic [N-1:0]    exp_v;
        in_valid = 1'b1;
        in_data  = {N{8'd5}};
        in_last  = 1'b1;
        step();
        in_data = {N{8'd6}};
        for (int c = 1; c <= 9; c++) begin
            if (c == 5) in_valid = 1'b0;
            exp_v = '0;
            exp_d = '0;
            for (int i = 0; i < N; i++) begin
                if (c == 1 + i) begin
                    exp_v[i]          = 1'b1;
                    exp_d[i*DW +: DW] = 8'd5;
                end else if (c == 5 + i) begin
                    exp_v[i]          = 1'b1;
                    exp_d[i*DW +: DW] = 8'd6;
                end
            end
            checks++;
            if (out_valid !== exp_v || out_data !== exp_d) begin
                errors++;
                $display("FAIL bp_out c=%0d: got %b/%h want %b/%h", c, out_valid, out_data, exp_v, exp_d);
            end
            checks++;
            if (in_ready !== (c == 4 || c >= 8) || done !== (c == 4 || c == 8)) begin
                errors++;
                $display("FAIL bp_ctrl c=%0d: got ready=%b done=%b want %b/%b",
                         c, in_ready, done, c == 4 || c >= 8, c == 4 || c == 8);
            end
            step();
        end
        in_last = 1'b0;
    endtask

    // Reset pulsed two cycles after the last accept: no done, everything idle.
    task automatic test_reset_drain();
        in_valid = 1'b1;
        in_data  = 32'h11223344;
        in_last  = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== '0 || out_data !== '0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstdrain_now: got valid=%b data=%h done=%b busy=%b", out_valid, out_data, done, busy);
        end
        @(negedge clk) n_rst = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            checks++;
            if (done !== 1'b0 || out_valid !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rstdrain_after c=%0d: got done=%b valid=%b busy=%b ready=%b",
                         c, done, out_valid, busy, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_bubble();
        test_backpressure();
        test_reset_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
